// File: rtl/mem_port_arbiter_if.sv
// AXI4-lite channel bundle shared by the arbiter's requester and memory ports.
interface axi4lite #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master AXI4-lite arbiter (fetch read-only, data read/write) onto one memory port.
// Optional performance counters are built when ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned PERF_CNT_W   = 32
) (
  input  logic    clk,
  input  logic    rst,
  axi4lite.slave  ifetch_port,
  axi4lite.slave  data_port,
  axi4lite.master mem_port,
  output logic    busy
`ifdef ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_fetch_grants,
  output logic [PERF_CNT_W-1:0] perf_data_grants,
  output logic [PERF_CNT_W-1:0] perf_fetch_stall_cycles
`endif
);

  localparam int unsigned   SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_RESP, WR_ADDR, WR_RESP} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  logic f_req, dr_req, dw_req;
  logic fetch_grant, data_grant;
  logic ar_fire, r_fire, aw_fire, w_fire, b_fire;

  assign f_req  = ifetch_port.arvalid;
  assign dr_req = data_port.arvalid;
  assign dw_req = data_port.awvalid | data_port.wvalid;
  assign busy   = (state_q != IDLE);

  logic unused_fetch_wr;
  assign unused_fetch_wr = ^{ifetch_port.awvalid, ifetch_port.awaddr, ifetch_port.awprot,
                             ifetch_port.wvalid, ifetch_port.wdata, ifetch_port.wstrb,
                             ifetch_port.bready};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_FETCH;
      starve_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    fetch_grant = 1'b0;
    data_grant  = 1'b0;
    ar_fire     = 1'b0;
    r_fire      = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    b_fire      = 1'b0;

    mem_port.awvalid = 1'b0;
    mem_port.awaddr  = '0;
    mem_port.awprot  = '0;
    mem_port.wvalid  = 1'b0;
    mem_port.wdata   = '0;
    mem_port.wstrb   = '0;
    mem_port.bready  = 1'b0;
    mem_port.arvalid = 1'b0;
    mem_port.araddr  = '0;
    mem_port.arprot  = '0;
    mem_port.rready  = 1'b0;

    ifetch_port.awready = 1'b0;
    ifetch_port.wready  = 1'b0;
    ifetch_port.bvalid  = 1'b0;
    ifetch_port.bresp   = '0;
    ifetch_port.arready = 1'b0;
    ifetch_port.rvalid  = 1'b0;
    ifetch_port.rdata   = '0;
    ifetch_port.rresp   = '0;

    data_port.awready = 1'b0;
    data_port.wready  = 1'b0;
    data_port.bvalid  = 1'b0;
    data_port.bresp   = '0;
    data_port.arready = 1'b0;
    data_port.rvalid  = 1'b0;
    data_port.rdata   = '0;
    data_port.rresp   = '0;

    unique case (state_q)
      IDLE: begin
        // Starved fetch outranks even a pending data write.
        if (f_req && (starve_q == LIMIT)) begin
          fetch_grant = 1'b1;
        end else if (dw_req) begin
          data_grant = 1'b1;
          state_d    = WR_ADDR;
        end else if (dr_req) begin
          data_grant = 1'b1;
          state_d    = RD_ADDR;
        end else if (f_req) begin
          fetch_grant = 1'b1;
        end
        if (fetch_grant) begin
          owner_d  = OWN_FETCH;
          state_d  = RD_ADDR;
          starve_d = '0;
        end
        if (data_grant) begin
          owner_d  = OWN_DATA;
          starve_d = !f_req ? '0 : (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
        end
      end

      RD_ADDR: begin
        if (owner_q == OWN_FETCH) begin
          mem_port.arvalid    = ifetch_port.arvalid;
          mem_port.araddr     = ifetch_port.araddr;
          mem_port.arprot     = ifetch_port.arprot;
          ifetch_port.arready = mem_port.arready;
          ar_fire             = ifetch_port.arvalid & mem_port.arready;
        end else begin
          mem_port.arvalid  = data_port.arvalid;
          mem_port.araddr   = data_port.araddr;
          mem_port.arprot   = data_port.arprot;
          data_port.arready = mem_port.arready;
          ar_fire           = data_port.arvalid & mem_port.arready;
        end
        if (ar_fire) state_d = RD_RESP;
      end

      RD_RESP: begin
        if (owner_q == OWN_FETCH) begin
          ifetch_port.rvalid = mem_port.rvalid;
          ifetch_port.rdata  = mem_port.rdata;
          ifetch_port.rresp  = mem_port.rresp;
          mem_port.rready    = ifetch_port.rready;
          r_fire             = mem_port.rvalid & ifetch_port.rready;
        end else begin
          data_port.rvalid = mem_port.rvalid;
          data_port.rdata  = mem_port.rdata;
          data_port.rresp  = mem_port.rresp;
          mem_port.rready  = data_port.rready;
          r_fire           = mem_port.rvalid & data_port.rready;
        end
        if (r_fire) state_d = IDLE;
      end

      WR_ADDR: begin
        // AW and W complete independently; a finished channel stops presenting valid.
        mem_port.awvalid  = data_port.awvalid & ~aw_done_q;
        mem_port.awaddr   = data_port.awaddr;
        mem_port.awprot   = data_port.awprot;
        data_port.awready = mem_port.awready & ~aw_done_q;
        mem_port.wvalid   = data_port.wvalid & ~w_done_q;
        mem_port.wdata    = data_port.wdata;
        mem_port.wstrb    = data_port.wstrb;
        data_port.wready  = mem_port.wready & ~w_done_q;
        aw_fire   = data_port.awvalid & ~aw_done_q & mem_port.awready;
        w_fire    = data_port.wvalid & ~w_done_q & mem_port.wready;
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end

      WR_RESP: begin
        data_port.bvalid = mem_port.bvalid;
        data_port.bresp  = mem_port.bresp;
        mem_port.bready  = data_port.bready;
        b_fire           = mem_port.bvalid & data_port.bready;
        if (b_fire) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_PERF_EN
  logic [PERF_CNT_W-1:0] fetch_grants_q, data_grants_q, fetch_stall_q;
  logic                  fetch_stall;

  assign fetch_stall = ifetch_port.arvalid & ~((state_q != IDLE) && (owner_q == OWN_FETCH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_grants_q <= '0;
      data_grants_q  <= '0;
      fetch_stall_q  <= '0;
    end else begin
      if (fetch_grant && (fetch_grants_q != '1)) fetch_grants_q <= fetch_grants_q + 1'b1;
      if (data_grant && (data_grants_q != '1))   data_grants_q  <= data_grants_q + 1'b1;
      if (fetch_stall && (fetch_stall_q != '1))  fetch_stall_q  <= fetch_stall_q + 1'b1;
    end
  end

  assign perf_fetch_grants       = fetch_grants_q;
  assign perf_data_grants        = data_grants_q;
  assign perf_fetch_stall_cycles = fetch_stall_q;
`else
  logic [PERF_CNT_W-1:0] unused_perf_w;
  assign unused_perf_w = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized request mixes
// checked against a grant-order model; memory side is played by the bench.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  axi4lite f_if ();
  axi4lite d_if ();
  axi4lite m_if ();

`ifdef ARB_PERF_EN
  logic [31:0] perf_fg, perf_dg, perf_fs;
`endif

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .PERF_CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ifetch_port(f_if),
    .data_port  (d_if),
    .mem_port   (m_if),
    .busy       (busy)
`ifdef ARB_PERF_EN
    ,
    .perf_fetch_grants      (perf_fg),
    .perf_data_grants       (perf_dg),
    .perf_fetch_stall_cycles(perf_fs)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests, their payloads, starvation count, grant totals.
  bit          pf, pr, pw;
  logic [31:0] fa, ra, wa, wd;
  int          m_starve;
  int          n_fg, n_dg;
  int          pat [6] = '{1, 1, 1, 1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_drv();
    f_if.awvalid = 0; f_if.awaddr = '0; f_if.awprot = '0; f_if.wvalid = 0;
    f_if.wdata = '0; f_if.wstrb = '0; f_if.bready = 1; f_if.arvalid = 0;
    f_if.araddr = '0; f_if.arprot = '0; f_if.rready = 1;
    d_if.awvalid = 0; d_if.awaddr = '0; d_if.awprot = '0; d_if.wvalid = 0;
    d_if.wdata = '0; d_if.wstrb = '0; d_if.bready = 1; d_if.arvalid = 0;
    d_if.araddr = '0; d_if.arprot = '0; d_if.rready = 1;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = '0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_drv();
    pf = 0; pr = 0; pw = 0;
    m_starve = 0; n_fg = 0; n_dg = 0;
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic req_fetch(input logic [31:0] a);
    f_if.arvalid = 1; f_if.araddr = a; pf = 1; fa = a;
  endtask

  task automatic req_dread(input logic [31:0] a);
    d_if.arvalid = 1; d_if.araddr = a; pr = 1; ra = a;
  endtask

  task automatic req_dwrite(input logic [31:0] a, input logic [31:0] dat, input bit wv);
    d_if.awvalid = 1; d_if.awaddr = a; d_if.wdata = dat; d_if.wstrb = '1;
    d_if.wvalid = wv; pw = 1; wa = a; wd = dat;
  endtask

  // 0 = fetch read, 1 = data read, 2 = data write
  function automatic int predict();
    if (pf && m_starve == LIMIT) return 0;
    if (pw) return 2;
    if (pr) return 1;
    return 0;
  endfunction

  task automatic serve(input string tag, input int exp_who, input logic [31:0] rdata,
                       input logic [1:0] rresp, input int w_delay, output int act_who);
    int n;
    bit is_wr, aw_done, w_done, aw_hs, w_hs;
    n = 0;
    act_who = exp_who;
    chk({tag, ":idle_quiet"}, {29'b0, m_if.arvalid, m_if.awvalid, m_if.wvalid}, 0);
    chk({tag, ":idle_busy"}, {31'b0, busy}, 0);
    while (!(m_if.arvalid === 1'b1 || m_if.awvalid === 1'b1 || m_if.wvalid === 1'b1) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ":grant_lat"}, n, 1);
    if (n >= 20) return;
    chk({tag, ":busy_addr"}, {31'b0, busy}, 1);
    is_wr = (m_if.awvalid === 1'b1) || (m_if.wvalid === 1'b1);
    chk({tag, ":kind"}, {31'b0, is_wr}, {31'b0, exp_who == 2});
    if (!is_wr) begin
      repeat ($urandom_range(0, 2)) tick();
      m_if.arready = 1;
      #1;
      act_who = (f_if.arready === 1'b1) ? 0 : 1;
      chk({tag, ":ar_onehot"}, {31'b0, f_if.arready ^ d_if.arready}, 1);
      chk({tag, ":owner"}, act_who, exp_who);
      chk({tag, ":araddr"}, m_if.araddr, (act_who == 0) ? fa : ra);
      tick();
      m_if.arready = 0;
      if (act_who == 0) begin f_if.arvalid = 0; pf = 0; end
      else begin d_if.arvalid = 0; pr = 0; end
      repeat ($urandom_range(0, 2)) tick();
      m_if.rvalid = 1; m_if.rdata = rdata; m_if.rresp = rresp;
      #1;
      chk({tag, ":busy_resp"}, {31'b0, busy}, 1);
      if (act_who == 0) begin
        chk({tag, ":f_rvalid"}, {31'b0, f_if.rvalid}, 1);
        chk({tag, ":f_rdata"}, f_if.rdata, rdata);
        chk({tag, ":f_rresp"}, {30'b0, f_if.rresp}, {30'b0, rresp});
        chk({tag, ":d_rvalid"}, {31'b0, d_if.rvalid}, 0);
      end else begin
        chk({tag, ":d_rvalid"}, {31'b0, d_if.rvalid}, 1);
        chk({tag, ":d_rdata"}, d_if.rdata, rdata);
        chk({tag, ":d_rresp"}, {30'b0, d_if.rresp}, {30'b0, rresp});
        chk({tag, ":f_rvalid"}, {31'b0, f_if.rvalid}, 0);
      end
      tick();
      m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = '0;
    end else begin
      act_who = 2;
      aw_done = 0;
      w_done  = 0;
      for (int k = 0; k < 60 && !(aw_done && w_done); k++) begin
        if (w_delay > 0 && k == w_delay - 1) d_if.wvalid = 1;
        m_if.awready = !aw_done && ($urandom_range(0, 1) == 1);
        m_if.wready  = !w_done && ($urandom_range(0, 1) == 1);
        #1;
        aw_hs = (m_if.awvalid === 1'b1) && m_if.awready;
        w_hs  = (m_if.wvalid === 1'b1) && m_if.wready;
        if (!aw_done) chk({tag, ":awready_fwd"}, {31'b0, d_if.awready}, {31'b0, m_if.awready});
        if (aw_hs) chk({tag, ":awaddr"}, m_if.awaddr, wa);
        if (w_hs)  chk({tag, ":wdata"}, m_if.wdata, wd);
        tick();
        m_if.awready = 0;
        m_if.wready  = 0;
        if (aw_hs) begin aw_done = 1; d_if.awvalid = 0; end
        if (w_hs)  begin w_done = 1; d_if.wvalid = 0; end
      end
      chk({tag, ":wr_both_done"}, {30'b0, aw_done, w_done}, 3);
      repeat ($urandom_range(0, 2)) tick();
      m_if.bvalid = 1; m_if.bresp = rresp;
      #1;
      chk({tag, ":d_bvalid"}, {31'b0, d_if.bvalid}, 1);
      chk({tag, ":d_bresp"}, {30'b0, d_if.bresp}, {30'b0, rresp});
      chk({tag, ":f_bvalid"}, {31'b0, f_if.bvalid}, 0);
      tick();
      m_if.bvalid = 0; m_if.bresp = '0;
      pw = 0;
    end
    chk({tag, ":end_idle"}, {31'b0, busy}, 0);
  endtask

  task automatic grant_step(input string tag, input logic [31:0] rdata, input logic [1:0] rresp,
                            input int w_delay, output int act);
    int who;
    who = predict();
    if (who != 0 && pf) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else m_starve = 0;
    if (who == 0) n_fg++; else n_dg++;
    serve(tag, who, rdata, rresp, w_delay, act);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act;
    clear_drv();
    pf = 0; pr = 0; pw = 0; m_starve = 0; n_fg = 0; n_dg = 0;
    rst = 1;
    // Drive requests and responses during reset: nothing may leak through.
    f_if.arvalid = 1; f_if.araddr = 32'h44;
    d_if.arvalid = 1; d_if.awvalid = 1; d_if.wvalid = 1; d_if.wdata = 32'h55;
    m_if.arready = 1; m_if.awready = 1; m_if.wready = 1; m_if.rvalid = 1; m_if.bvalid = 1;
    m_if.rdata = 32'h66;
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_mem_valid", {27'b0, m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready}, 0);
    chk("rst_mem_addr", m_if.araddr | m_if.awaddr | m_if.wdata, 0);
    chk("rst_f_out", {28'b0, f_if.arready, f_if.rvalid, f_if.awready, f_if.bvalid}, 0);
    chk("rst_d_out", {27'b0, d_if.arready, d_if.rvalid, d_if.awready, d_if.wready, d_if.bvalid}, 0);
    chk("rst_rdata", f_if.rdata | d_if.rdata, 0);
    do_reset();

    // Lone fetch read.
    req_fetch(32'h100);
    grant_step("fetch_lone", 32'h0000_0013, 2'b00, 0, act);

    // Data writes: AW/W together, then W three cycles late.
    req_dwrite(32'h2000, 32'hDEAD_BEEF, 1'b1);
    grant_step("wr_together", '0, 2'b00, 0, act);
    req_dwrite(32'h2000, 32'hDEAD_BEEF, 1'b0);
    grant_step("wr_w_late", '0, 2'b00, 3, act);

    // Simultaneous data read and fetch read.
    req_dread(32'h3000);
    req_fetch(32'h4);
    grant_step("simul_1", 32'hCAFE_0001, 2'b00, 0, act);
    chk("simul_first_data", act, 1);
    grant_step("simul_2", 32'hCAFE_0002, 2'b10, 0, act);
    chk("simul_second_fetch", act, 0);

    // Reset while waiting for the read response.
    do_reset();
    req_fetch(32'h80);
    tick();
    chk("rst_mid_ar", {31'b0, m_if.arvalid}, 1);
    m_if.arready = 1;
    tick();
    m_if.arready = 0;
    f_if.arvalid = 0;
    pf = 0;
    chk("rst_mid_busy_before", {31'b0, busy}, 1);
    rst = 1;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 0);
    chk("rst_mid_mem_valid", {27'b0, m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready}, 0);
    m_if.rvalid = 1; m_if.rdata = 32'hBAD0_BAD0;
    #1;
    chk("rst_mid_f_rvalid", {31'b0, f_if.rvalid}, 0);
    tick();
    rst = 0;
    #1;
    chk("rst_mid_f_rvalid_post", {30'b0, f_if.rvalid, d_if.rvalid}, 0);
    tick();
    chk("rst_mid_idle", {31'b0, busy}, 0);
    m_if.rvalid = 0; m_if.rdata = '0;

    // Starvation: continuous data reads with fetch pending.
    do_reset();
    req_fetch(32'h40);
    for (int i = 0; i < 6; i++) begin
      if (!pr) req_dread(32'h5000 + 32'(i * 16));
      grant_step($sformatf("starve%0d", i), $urandom, 2'b00, 0, act);
      chk($sformatf("starve_seq%0d", i), act, pat[i]);
    end

    // Randomized request mixes.
    for (int it = 0; it < 40; it++) begin
      if (!pf && $urandom_range(0, 1) == 1) req_fetch($urandom & 32'h0000_0FFC);
      if (!pr && $urandom_range(0, 1) == 1) req_dread(32'h1000_0000 | ($urandom & 32'h0000_FFFC));
      if (!pw && $urandom_range(0, 2) == 2) req_dwrite(32'h2000_0000 | ($urandom & 32'h0000_FFFC), $urandom, 1'b1);
      if (!pf && !pr && !pw) req_fetch($urandom & 32'h0000_0FFC);
      grant_step($sformatf("rnd%0d", it), $urandom, 2'($urandom_range(0, 3)), 0, act);
    end

`ifdef ARB_PERF_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_fetch(32'h200 + 32'(i * 4));
      grant_step($sformatf("perf_f%0d", i), $urandom, 2'b00, 0, act);
    end
    for (int i = 0; i < 2; i++) begin
      req_dread(32'h6000 + 32'(i * 4));
      grant_step($sformatf("perf_d%0d", i), $urandom, 2'b00, 0, act);
    end
    chk("perf_fetch_grants", perf_fg, n_fg);
    chk("perf_data_grants", perf_dg, n_dg);
    chk("perf_fetch_three", perf_fg, 3);
    rst = 1;
    #1;
    chk("perf_rst_clear", perf_fg | perf_dg, 0);
    tick();
    rst = 0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
